// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths and request type for the 1RW+1R SRAM front-end
package sram_ctrl_pkg;

  localparam int DATA_WIDTH = 44;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_WMASKS = 6;
  localparam int LANE_WIDTH = 8;

  // One port-A request as seen on the pins; lane 5 of wmask covers only [43:40]
  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - small first-word-visible response FIFO with occupancy count
module sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 44,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_valid = (count != '0);
  assign do_pop    = pop_valid && pop_ready;
  // The upstream credit check keeps us from overflowing; a push into a full
  // FIFO with no pop is dropped rather than corrupting the head entry.
  assign do_push   = push_valid && ((count != CW'(DEPTH)) || do_pop);
  // Head entry is a flop, so rdata is stable while valid && !ready
  assign pop_data  = mem[rd_ptr];

  // Storage: cleared on reset so rdata reads 0 out of reset
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; reset drops anything queued
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// rtl/sram_1rw1r_ctrl.sv - valid/ready front-end driving a 1RW+1R OpenRAM macro
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  // port A: read/write requests
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  // port B: read-only requests
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  // macro port 0 (RW)
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  // macro port 1 (R)
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  sram_req_t     a_req;
  logic          a_fire;
  logic          a_wr_fire;
  logic          a_rd_fire;
  logic          a_inflight;
  logic          a_pop;
  logic [CW-1:0] a_count;
  logic [CW:0]   a_level;
  logic          a_credit;

  logic          b_fire;
  logic          b_inflight;
  logic          b_pop;
  logic [CW-1:0] b_count;
  logic [CW:0]   b_level;
  logic          b_credit;
  logic          collision;

  assign a_req = '{we: a_req_we, wmask: a_req_wmask, addr: a_req_addr, wdata: a_req_wdata};

  assign a_pop = a_rsp_valid && a_rsp_ready;
  assign b_pop = b_rsp_valid && b_rsp_ready;

  // Credit: entries queued plus the read landing this cycle, minus a same-cycle
  // pop, must leave room for one more. The pop term makes rsp_ready feed req_ready
  // combinationally so a full FIFO being drained keeps the pipe at one read/cycle.
  always_comb begin
    a_level  = {1'b0, a_count} + {{CW{1'b0}}, a_inflight} - {{CW{1'b0}}, a_pop};
    b_level  = {1'b0, b_count} + {{CW{1'b0}}, b_inflight} - {{CW{1'b0}}, b_pop};
    a_credit = a_level < (CW + 1)'(RSP_DEPTH);
    b_credit = b_level < (CW + 1)'(RSP_DEPTH);
  end

  // Writes never need a response slot; rstb0 gates ready so nothing is issued in reset
  assign a_req_ready = rstb0 && (a_req.we || a_credit);
  assign a_fire      = a_req_valid && a_req_ready;
  assign a_wr_fire   = a_fire && a_req.we;
  assign a_rd_fire   = a_fire && !a_req.we;

  // A write and a B read of the same word in one cycle would race inside the
  // macro; A wins and B is held off for that cycle.
  assign collision   = a_wr_fire && (a_req.addr == b_req_addr);
  assign b_req_ready = rstb0 && b_credit && !collision;
  assign b_fire      = b_req_valid && b_req_ready;

  // Macro pins are driven straight from the accepted request; idle reads as no-op
  assign csb0   = !a_fire;
  assign web0   = !a_wr_fire;
  assign wmask0 = a_wr_fire ? a_req.wmask : '0;
  assign addr0  = a_req.addr;
  assign din0   = a_req.wdata;
  assign csb1   = !b_fire;
  assign addr1  = b_req_addr;

  // Mark the cycle in which the macro presents read data for each port
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      a_inflight <= 1'b0;
      b_inflight <= 1'b0;
    end else begin
      a_inflight <= a_rd_fire;
      b_inflight <= b_fire;
    end
  end

  // dout is only pushed when inflight is set, so undriven macro output never lands
  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CW    (CW)
  ) u_a_rsp_fifo (
    .clk        (clk0),
    .rstb       (rstb0),
    .push_valid (a_inflight),
    .push_data  (dout0),
    .pop_valid  (a_rsp_valid),
    .pop_ready  (a_rsp_ready),
    .pop_data   (a_rsp_rdata),
    .count      (a_count)
  );

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CW    (CW)
  ) u_b_rsp_fifo (
    .clk        (clk0),
    .rstb       (rstb0),
    .push_valid (b_inflight),
    .push_data  (dout1),
    .pop_valid  (b_rsp_valid),
    .pop_ready  (b_rsp_ready),
    .pop_data   (b_rsp_rdata),
    .count      (b_count)
  );

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb/tb_sram_1rw1r_ctrl.sv - directed self-checking bench for sram_1rw1r_ctrl
module tb_sram_1rw1r_ctrl;
  import sram_ctrl_pkg::*;

  logic                  clk0 = 1'b0;
  logic                  rstb0;
  logic                  a_req_valid, a_req_ready, a_req_we;
  logic [NUM_WMASKS-1:0] a_req_wmask;
  logic [ADDR_WIDTH-1:0] a_req_addr;
  logic [DATA_WIDTH-1:0] a_req_wdata;
  logic                  a_rsp_valid, a_rsp_ready;
  logic [DATA_WIDTH-1:0] a_rsp_rdata;
  logic                  b_req_valid, b_req_ready;
  logic [ADDR_WIDTH-1:0] b_req_addr;
  logic                  b_rsp_valid, b_rsp_ready;
  logic [DATA_WIDTH-1:0] b_rsp_rdata;
  logic                  csb0, web0, csb1;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] din0, dout0, dout1;

  logic                  preload;
  logic [DATA_WIDTH-1:0] mem [64];
  int                    checks = 0;
  int                    errors = 0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_ctrl #(.RSP_DEPTH(2)) dut (
    .clk0        (clk0),
    .rstb0       (rstb0),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_wmask (a_req_wmask),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_ready (a_rsp_ready),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_addr  (b_req_addr),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_ready (b_rsp_ready),
    .b_rsp_rdata (b_rsp_rdata),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1)
  );

  function automatic logic [DATA_WIDTH-1:0] pat(input int i);
    return 44'h800_0000_0000 | 44'(i << 8) | 44'(i);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_bits(input logic [NUM_WMASKS-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int l = 0; l < NUM_WMASKS; l++)
      for (int b = 0; b < 8; b++)
        if (l * 8 + b < DATA_WIDTH) r[l * 8 + b] = m[l];
    return r;
  endfunction

  // Macro model: one-cycle read latency, random garbage on dout when not reading
  always @(posedge clk0) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (!csb0 && !web0) begin
      mem[addr0] <= (mem[addr0] & ~lane_bits(wmask0)) | (din0 & lane_bits(wmask0));
    end
    dout0 <= (!csb0 && web0) ? mem[addr0] : {12'($urandom), $urandom};
    dout1 <= (!csb1) ? mem[addr1] : {12'($urandom), $urandom};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk0);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_wmask = '0;
    a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_addr = '0;
  endtask

  task automatic a_rd(input logic [ADDR_WIDTH-1:0] ad);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_wmask = '0;
    a_req_addr = ad; a_req_wdata = '0;
  endtask

  task automatic a_wr(input logic [ADDR_WIDTH-1:0] ad, input logic [DATA_WIDTH-1:0] d,
                      input logic [NUM_WMASKS-1:0] m);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_wmask = m;
    a_req_addr = ad; a_req_wdata = d;
  endtask

  initial begin
    int                    acc;
    logic [ADDR_WIDTH-1:0] nxt;
    idle;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    rstb0 = 1'b0;
    preload = 1'b1;
    repeat (2) @(posedge clk0);
    #1;
    preload = 1'b0;

    // reset state, with requests pending on both ports
    a_rd(6'd5);
    b_req_valid = 1'b1; b_req_addr = 6'd7;
    settle;
    chk("rst_csb0", 64'(csb0), 64'(1));
    chk("rst_csb1", 64'(csb1), 64'(1));
    chk("rst_web0", 64'(web0), 64'(1));
    chk("rst_a_rdy", 64'(a_req_ready), 64'(0));
    chk("rst_b_rdy", 64'(b_req_ready), 64'(0));
    chk("rst_a_val", 64'(a_rsp_valid), 64'(0));
    chk("rst_b_val", 64'(b_rsp_valid), 64'(0));
    chk("rst_a_data", 64'(a_rsp_rdata), 64'(0));

    // first cycle after release: A read of addr 5, latency 2
    b_req_valid = 1'b0;
    rstb0 = 1'b1;
    settle;
    chk("rel_a_rdy", 64'(a_req_ready), 64'(1));
    chk("rel_csb0", 64'(csb0), 64'(0));
    chk("rel_web0", 64'(web0), 64'(1));
    chk("rel_addr0", 64'(addr0), 64'(5));
    tick;
    idle;
    settle;
    chk("lat_k1_val", 64'(a_rsp_valid), 64'(0));
    chk("idle_csb0", 64'(csb0), 64'(1));
    chk("idle_wmask0", 64'(wmask0), 64'(0));
    tick;
    settle;
    chk("lat_k2_val", 64'(a_rsp_valid), 64'(1));
    chk("lat_k2_data", 64'(a_rsp_rdata), 64'(pat(5)));
    tick;
    settle;
    chk("lat_pop_val", 64'(a_rsp_valid), 64'(0));

    // back-to-back sweep on both ports
    for (int c = 0; c < 66; c++) begin
      if (c < 64) begin
        a_rd(c[5:0]);
        b_req_valid = 1'b1; b_req_addr = c[5:0];
      end else begin
        idle;
      end
      settle;
      if (c < 64) begin
        chk("sweep_a_rdy", 64'(a_req_ready), 64'(1));
        chk("sweep_b_rdy", 64'(b_req_ready), 64'(1));
      end
      if (c >= 2) begin
        chk("sweep_a_val", 64'(a_rsp_valid), 64'(1));
        chk("sweep_a_data", 64'(a_rsp_rdata), 64'(pat(c - 2)));
        chk("sweep_b_val", 64'(b_rsp_valid), 64'(1));
        chk("sweep_b_data", 64'(b_rsp_rdata), 64'(pat(c - 2)));
      end
      tick;
    end
    settle;
    chk("sweep_end_a", 64'(a_rsp_valid), 64'(0));
    chk("sweep_end_b", 64'(b_rsp_valid), 64'(0));

    // full write, byte-0 clear, lane-5 nibble write
    a_wr(6'd3, 44'hABC_DEF0_1234, 6'h3F);
    settle;
    chk("wr_rdy", 64'(a_req_ready), 64'(1));
    chk("wr_csb0", 64'(csb0), 64'(0));
    chk("wr_web0", 64'(web0), 64'(0));
    chk("wr_wmask0", 64'(wmask0), 64'(6'h3F));
    chk("wr_din0", 64'(din0), 64'(44'hABC_DEF0_1234));
    tick;
    a_wr(6'd3, 44'h0, 6'h01);
    tick;
    a_wr(6'd4, 44'hFFF_FFFF_FFFF, 6'h20);
    tick;
    a_rd(6'd3);
    tick;
    a_rd(6'd4);
    tick;
    idle;
    settle;
    chk("partial_val", 64'(a_rsp_valid), 64'(1));
    chk("partial_data", 64'(a_rsp_rdata), 64'(44'hABC_DEF0_1200));
    tick;
    settle;
    chk("lane5_data", 64'(a_rsp_rdata), 64'(44'hF00_0000_0404));
    tick;
    settle;
    chk("partial_end", 64'(a_rsp_valid), 64'(0));

    // backpressure: only two reads accepted while a_rsp_ready is low
    a_rsp_ready = 1'b0;
    acc = 0;
    nxt = 6'd10;
    for (int c = 0; c < 5; c++) begin
      a_rd(nxt);
      settle;
      if (a_req_ready) begin
        acc++;
        nxt = nxt + 1'b1;
      end
      tick;
    end
    chk("stall_accepts", 64'(acc), 64'(2));
    a_rd(nxt);
    settle;
    chk("stall_rdy", 64'(a_req_ready), 64'(0));
    chk("stall_val", 64'(a_rsp_valid), 64'(1));
    chk("stall_hold", 64'(a_rsp_rdata), 64'(pat(10)));
    a_wr(6'd20, 44'h0DE_ADBE_EF55, 6'h3F);
    settle;
    chk("stall_wr_rdy", 64'(a_req_ready), 64'(1));
    tick;
    a_rd(nxt);
    settle;
    chk("stall_rdy2", 64'(a_req_ready), 64'(0));
    idle;
    a_rsp_ready = 1'b1;
    settle;
    chk("drain0_val", 64'(a_rsp_valid), 64'(1));
    chk("drain0_data", 64'(a_rsp_rdata), 64'(pat(10)));
    tick;
    settle;
    chk("drain1_data", 64'(a_rsp_rdata), 64'(pat(11)));
    tick;
    settle;
    chk("drain_end", 64'(a_rsp_valid), 64'(0));
    a_rd(6'd20);
    settle;
    chk("resume_rdy", 64'(a_req_ready), 64'(1));
    tick;
    idle;
    tick;
    settle;
    chk("stall_wr_data", 64'(a_rsp_rdata), 64'(44'h0DE_ADBE_EF55));
    tick;

    // same-address collision, then next-cycle B read sees the write
    a_wr(6'd9, 44'h123_4567_89AB, 6'h3F);
    b_req_valid = 1'b1; b_req_addr = 6'd9;
    settle;
    chk("coll_b_rdy", 64'(b_req_ready), 64'(0));
    chk("coll_csb1", 64'(csb1), 64'(1));
    chk("coll_a_rdy", 64'(a_req_ready), 64'(1));
    tick;
    a_req_valid = 1'b0;
    settle;
    chk("coll_retry_rdy", 64'(b_req_ready), 64'(1));
    tick;
    b_req_valid = 1'b0;
    tick;
    settle;
    chk("coll_b_val", 64'(b_rsp_valid), 64'(1));
    chk("coll_b_data", 64'(b_rsp_rdata), 64'(44'h123_4567_89AB));
    tick;
    a_wr(6'd9, 44'h555_5555_5555, 6'h3F);
    b_req_valid = 1'b1; b_req_addr = 6'd8;
    settle;
    chk("nocoll_b_rdy", 64'(b_req_ready), 64'(1));
    tick;
    idle;
    tick;
    settle;
    chk("nocoll_b_data", 64'(b_rsp_rdata), 64'(pat(8)));
    tick;

    // reset with one read queued and one in flight
    a_rsp_ready = 1'b0;
    a_rd(6'd1);
    tick;
    a_rd(6'd2);
    tick;
    idle;
    rstb0 = 1'b0;
    settle;
    chk("mid_rst_val", 64'(a_rsp_valid), 64'(0));
    chk("mid_rst_rdy", 64'(a_req_ready), 64'(0));
    tick;
    rstb0 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle;
      chk("post_rst_val", 64'(a_rsp_valid), 64'(0));
      tick;
    end
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      a_rd(6'd30);
      settle;
      if (a_req_ready) acc++;
      tick;
    end
    chk("post_rst_accepts", 64'(acc), 64'(2));
    idle;
    a_rsp_ready = 1'b1;
    repeat (3) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
